sonar_formatador_n: RTL and testbench
=====================================

Name: sonar_formatador_n

Overview:
Parametrised record formatter and buffer for the sonar datapath. It accepts completed (angle, distance) measurements as BCD digit vectors and queues them in a DEPTH-entry FIFO. It then streams each record as 7-bit ASCII characters to a downstream serial transmitter using the partida/pronto handshake. The block generalises the fixed 3+3-digit, unbuffered "ddd,ddd#" formatter with:
- configurable digit counts, separator and terminator;
- record buffering with a drop counter;
- error rendering;
- optional leading-zero suppression.

Parameters:
N_ANG, 3, number of BCD digits in the angle field (1..4)
N_MED, 4, number of BCD digits in the distance field (1..5)
DEPTH, 4, FIFO depth in records (power of 2, 2..16)
SEP, 7'h2C, separator character (",")
TERM, 7'h23, terminator character ("#")
SUPRIME_ZEROS, 0, when 1, leading zeros of the distance field are printed as space (7'h20)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high; clears FIFO, counters and FSM
grava  in  1  one-cycle request to enqueue {erro, angulo, medida}
angulo  in  4*N_ANG  angle in BCD, most significant digit in the MSBs
medida  in  4*N_MED  distance in BCD, most significant digit in the MSBs
erro  in  1  measurement timed out; the distance field is rendered as '-'
pronto_tx  in  1  one-cycle pulse from the transmitter when a character is done
partida_tx  out  1  one-cycle start pulse to the transmitter
dados_ascii  out  7  current character
vazio  out  1  FIFO empty
cheio  out  1  FIFO full
ocupado  out  1  a record is being transmitted
fim_registro  out  1  one-cycle pulse after the TERM character completes
perdidos  out  8  count of dropped records, saturates at 255
db_estado  out  4  FSM state encoding, for debug

Behaviour:
- Reset values: partida_tx=0, dados_ascii=7'h00, vazio=1, cheio=0, ocupado=0, fim_registro=0, perdidos=0, db_estado=OCIOSO (4'h0). Reset mid-record abandons the record and flushes the FIFO. The transmitter is reset by the same signal.
- Record length: L = N_ANG + N_MED + 2 characters. Order: angle digits MSD first, then SEP, then distance digits MSD first, then TERM.
- Digit mapping:
  - BCD d in 0..9 maps to 7'h30+d.
  - d > 9 maps to '?' (7'h3F).
  - With erro=1, every distance digit is '-' (7'h2D); angle digits are unaffected.
  - With SUPRIME_ZEROS=1, distance digits of value 0 before the first nonzero digit are 7'h20. The last distance digit is always printed. Suppression does not apply when erro=1.
- FIFO: width 1+4*N_ANG+4*N_MED, synchronous write on grava.
  - grava while cheio with no pop in the same cycle: the record is dropped and perdidos increments (saturating).
  - grava while cheio with a pop in the same cycle: the record is accepted and occupancy is unchanged.
  - vazio and cheio are registered and reflect occupancy in the cycle after the update.
- FSM states:
  - OCIOSO (0): leaves when !vazio, goes to CARREGA.
  - CARREGA (1): pops the FIFO head into a record register, clears the character index i=0, sets ocupado=1. Goes to PARTIDA.
  - PARTIDA (2): drives dados_ascii = char(i) and pulses partida_tx for exactly one cycle. Goes to ESPERA.
  - ESPERA (3): holds dados_ascii stable. On pronto_tx: if i = L-1, go to FIM; otherwise i increments and the FSM goes to PARTIDA.
  - FIM (4): pulses fim_registro for one cycle, clears ocupado. Goes to CARREGA if !vazio, otherwise to OCIOSO.
- Latency: grava at cycle t with an idle block gives the first partida_tx at t+3 (t+1 !vazio, t+2 CARREGA, t+3 PARTIDA). Records are sent back-to-back with no idle gap beyond FIM+CARREGA.
- pronto_tx outside ESPERA is ignored. The record register is independent of the FIFO, so new grava during a transmission never alters the characters in flight.
- The index counter wraps only via CARREGA and never exceeds L-1.

Decomposition:
- Package sonar_pkg holds:
  - ASCII constants: ZERO 7'h30, ESPACO 7'h20, TRACO 7'h2D, INTERROG 7'h3F.
  - The FSM state encoding, 4-bit, values 0..4.
  - The bcd2ascii function.
- Sub-module fifo_sync_n (parameters DEPTH, WIDTH) provides write, read, vazio, cheio and simultaneous read/write. The formatter FSM, mux and drop counter stay in sonar_formatador_n.

Test Plan:
1. Defaults (N_ANG=3, N_MED=4). grava with angulo=12'h045, medida=16'h0123, erro=0. A bench transmitter model returns pronto_tx 5 cycles after each partida_tx. The bench must see this sequence, then exactly one fim_registro pulse: 30 34 35 2C 30 31 32 33 23.
2. SUPRIME_ZEROS=1, medida=16'h0007 → distance chars 20 20 20 37. With medida=16'h0000 → 20 20 20 30.
3. erro=1, angulo=12'h180 → 31 38 30 2C 2D 2D 2D 2D 23. medida=16'h0A00 with erro=0 → 30 3F 30 30.
4. Burst of 6 grava on consecutive cycles during an ongoing transmission, DEPTH=4 → 4 queued, perdidos=2. Records come out in order with back-to-back timing; vazio=1 after the last fim_registro.
5. FIFO full, grava in the same cycle as the CARREGA pop → accepted, perdidos unchanged, cheio stays 1.
6. reset asserted in ESPERA at character index 3 → next cycle: partida_tx=0, vazio=1, ocupado=0, db_estado=0. A stray pronto_tx afterwards produces no partida_tx.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared definitions for the sonar record formatter: ASCII constants,
// formatter FSM encoding and the BCD-to-ASCII digit mapping.
package sonar_pkg;

  localparam logic [6:0] ZERO     = 7'h30;
  localparam logic [6:0] ESPACO   = 7'h20;
  localparam logic [6:0] TRACO    = 7'h2D;
  localparam logic [6:0] INTERROG = 7'h3F;

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    PARTIDA = 4'h2,
    ESPERA  = 4'h3,
    FIM     = 4'h4
  } estado_t;

  // Digits 0..9 become '0'..'9'; anything above 9 is shown as '?'.
  function automatic logic [6:0] bcd2ascii(input logic [3:0] d);
    if (d > 4'd9) return INTERROG;
    return ZERO + {3'b000, d};
  endfunction

endpackage

// File: rtl/fifo_sync_n.sv
// Synchronous FIFO with registered empty/full flags. A write while full is
// accepted only when a read happens in the same cycle.
module fifo_sync_n #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             escreve,
  input  logic             le,
  input  logic [WIDTH-1:0] dado_in,
  output logic [WIDTH-1:0] dado_out,
  output logic             vazio,
  output logic             cheio
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             vazio_q, cheio_q;
  logic             le_ok, escreve_ok;

  assign le_ok      = le && !vazio_q;
  assign escreve_ok = escreve && (!cheio_q || le_ok);
  assign count_d    = count_q + CW'(escreve_ok) - CW'(le_ok);

  // Storage array: written on accepted pushes only.
  // NOTE: the storage is deliberately not reset; stale entries are never
  // visible because the pointers and flags are reset.
  always_ff @(posedge clock) begin
    if (escreve_ok) mem_q[wr_ptr_q] <= dado_in;
  end

  // Pointers, occupancy and registered flags.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      vazio_q  <= 1'b1;
      cheio_q  <= 1'b0;
    end else begin
      if (escreve_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (le_ok)      rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      vazio_q <= (count_d == '0);
      cheio_q <= (count_d == CW'(DEPTH));
    end
  end

  assign dado_out = mem_q[rd_ptr_q];
  assign vazio    = vazio_q;
  assign cheio    = cheio_q;

endmodule

// File: rtl/sonar_formatador_n.sv
// Buffers (angle, distance) BCD records and streams each one as ASCII
// characters "angle SEP distance TERM" through the partida/pronto handshake.
module sonar_formatador_n
  import sonar_pkg::*;
#(
  parameter int         N_ANG         = 3,
  parameter int         N_MED         = 4,
  parameter int         DEPTH         = 4,
  parameter logic [6:0] SEP           = 7'h2C,
  parameter logic [6:0] TERM          = 7'h23,
  parameter int         SUPRIME_ZEROS = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               grava,
  input  logic [4*N_ANG-1:0] angulo,
  input  logic [4*N_MED-1:0] medida,
  input  logic               erro,
  input  logic               pronto_tx,
  output logic               partida_tx,
  output logic [6:0]         dados_ascii,
  output logic               vazio,
  output logic               cheio,
  output logic               ocupado,
  output logic               fim_registro,
  output logic [7:0]         perdidos,
  output logic [3:0]         db_estado
);

  localparam int L  = N_ANG + N_MED + 2;
  localparam int IW = $clog2(L);
  localparam int W  = 1 + 4*N_ANG + 4*N_MED;

  estado_t       estado_q, estado_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  rec_q, rec_d;
  logic          ocupado_q, ocupado_d;
  logic [7:0]    perdidos_q, perdidos_d;
  logic          pop;
  logic [W-1:0]  fifo_out;
  logic          fifo_vazio, fifo_cheio;

  logic               rec_erro;
  logic [4*N_ANG-1:0] rec_ang;
  logic [4*N_MED-1:0] rec_med;
  logic [6:0]         chars [L];
  logic               lider;
  logic [3:0]         dig;

  fifo_sync_n #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .escreve  (grava),
    .le       (pop),
    .dado_in  ({erro, angulo, medida}),
    .dado_out (fifo_out),
    .vazio    (fifo_vazio),
    .cheio    (fifo_cheio)
  );

  assign rec_erro = rec_q[W-1];
  assign rec_ang  = rec_q[W-2 -: 4*N_ANG];
  assign rec_med  = rec_q[4*N_MED-1:0];

  // Renders the whole held record as a character array indexed by idx_q.
  always_comb begin
    lider = 1'b1;
    dig   = '0;
    for (int k = 0; k < N_ANG; k++)
      chars[k] = bcd2ascii(rec_ang[4*(N_ANG-1-k) +: 4]);
    chars[N_ANG] = SEP;
    for (int k = 0; k < N_MED; k++) begin
      dig = rec_med[4*(N_MED-1-k) +: 4];
      if (rec_erro)
        chars[N_ANG+1+k] = TRACO;
      else if (SUPRIME_ZEROS != 0 && lider && dig == 4'd0 && k != N_MED-1)
        chars[N_ANG+1+k] = ESPACO;
      else
        chars[N_ANG+1+k] = bcd2ascii(dig);
      if (dig != 4'd0) lider = 1'b0;
    end
    chars[L-1] = TERM;
  end

  // Next-state logic for the formatter FSM and the drop counter.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_d     = estado_q;
    idx_d        = idx_q;
    rec_d        = rec_q;
    ocupado_d    = ocupado_q;
    pop          = 1'b0;
    partida_tx   = 1'b0;
    fim_registro = 1'b0;
    unique case (estado_q)
      OCIOSO:  if (!fifo_vazio) estado_d = CARREGA;
      CARREGA: begin
        pop       = 1'b1;
        rec_d     = fifo_out;
        idx_d     = '0;
        ocupado_d = 1'b1;
        estado_d  = PARTIDA;
      end
      PARTIDA: begin
        partida_tx = 1'b1;
        estado_d   = ESPERA;
      end
      ESPERA: if (pronto_tx) begin
        if (idx_q == IW'(L-1)) estado_d = FIM;
        else begin
          idx_d    = idx_q + IW'(1);
          estado_d = PARTIDA;
        end
      end
      FIM: begin
        fim_registro = 1'b1;
        ocupado_d    = 1'b0;
        estado_d     = fifo_vazio ? OCIOSO : CARREGA;
      end
      default: estado_d = OCIOSO;
    endcase

    perdidos_d = perdidos_q;
    if (grava && fifo_cheio && !pop && perdidos_q != 8'hFF)
      perdidos_d = perdidos_q + 8'd1;
  end

  // State, record and counter registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      idx_q      <= '0;
      rec_q      <= '0;
      ocupado_q  <= 1'b0;
      perdidos_q <= '0;
    end else begin
      estado_q   <= estado_d;
      idx_q      <= idx_d;
      rec_q      <= rec_d;
      ocupado_q  <= ocupado_d;
      perdidos_q <= perdidos_d;
    end
  end

  assign dados_ascii = (estado_q == PARTIDA || estado_q == ESPERA) ? chars[idx_q] : 7'h00;
  assign vazio       = fifo_vazio;
  assign cheio       = fifo_cheio;
  assign ocupado     = ocupado_q;
  assign perdidos    = perdidos_q;
  assign db_estado   = estado_q;

endmodule

// File: tb/tb_sonar_formatador_n.sv
// Bench for sonar_formatador_n: a plain instance and one with leading-zero
// suppression share stimulus; a transmitter model answers each start pulse.
module tb_sonar_formatador_n;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, grava, erro, pronto_m, pronto_man, pronto_tx;
  logic [11:0] angulo;
  logic [15:0] medida;

  logic       partida_a, vazio_a, cheio_a, ocupado_a, fim_a;
  logic [6:0] dados_a;
  logic [7:0] perdidos_a;
  logic [3:0] db_a;
  logic       partida_z, vazio_z, cheio_z, ocupado_z, fim_z;
  logic [6:0] dados_z;
  logic [7:0] perdidos_z;
  logic [3:0] db_z;

  assign pronto_tx = pronto_m | pronto_man;

  sonar_formatador_n dut_a (
    .clock(clock), .reset(reset), .grava(grava), .angulo(angulo), .medida(medida),
    .erro(erro), .pronto_tx(pronto_tx), .partida_tx(partida_a), .dados_ascii(dados_a),
    .vazio(vazio_a), .cheio(cheio_a), .ocupado(ocupado_a), .fim_registro(fim_a),
    .perdidos(perdidos_a), .db_estado(db_a)
  );

  sonar_formatador_n #(.SUPRIME_ZEROS(1)) dut_z (
    .clock(clock), .reset(reset), .grava(grava), .angulo(angulo), .medida(medida),
    .erro(erro), .pronto_tx(pronto_tx), .partida_tx(partida_z), .dados_ascii(dados_z),
    .vazio(vazio_z), .cheio(cheio_z), .ocupado(ocupado_z), .fim_registro(fim_z),
    .perdidos(perdidos_z), .db_estado(db_z)
  );

  // Transmitter model: pronto_tx pulses 5 cycles after each partida_tx.
  int tx_cnt = 0;
  always @(negedge clock) begin
    if (reset) begin
      tx_cnt   = 0;
      pronto_m = 1'b0;
    end else begin
      pronto_m = 1'b0;
      if (tx_cnt != 0) begin
        tx_cnt--;
        if (tx_cnt == 0) pronto_m = 1'b1;
      end
      if (partida_a) tx_cnt = 5;
    end
  end

  typedef struct {
    logic [11:0]     ang;
    logic [15:0]     med;
    logic            erro;
    logic [8:0][7:0] exp_a;
    logic [8:0][7:0] exp_z;
  } vec_t;

  vec_t       vecs [6];
  logic [6:0] q_a [$];
  logic [6:0] q_z [$];
  int total = 0;
  int bad = 0;
  int rec_chars = 0;

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h @%0t", nome, got, exp, $time);
    end
  endtask

  task automatic drive_grava(input int n, input bit aceito);
    grava  = 1'b1;
    angulo = vecs[n].ang;
    medida = vecs[n].med;
    erro   = vecs[n].erro;
    if (aceito)
      for (int k = 0; k < 9; k++) begin
        q_a.push_back(vecs[n].exp_a[8-k][6:0]);
        q_z.push_back(vecs[n].exp_z[8-k][6:0]);
      end
    @(negedge clock);
    grava = 1'b0;
  endtask

  task automatic wait_fim(input string nome);
    bit got = 1'b0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clock);
      if (fim_a) got = 1'b1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL timeout %s: no fim_registro", nome);
    end
  endtask

  // Scoreboard: pops the expected character whenever a start pulse is seen.
  task automatic monitor();
    logic [6:0] ea, ez;
    forever begin
      @(negedge clock);
      if (reset) rec_chars = 0;
      else begin
        if (partida_a) begin
          check("partida_z_sync", {31'd0, partida_z}, 32'd1);
          check("char_expected", {31'd0, q_a.size() != 0}, 32'd1);
          if (q_a.size() != 0) begin
            ea = q_a.pop_front();
            ez = q_z.pop_front();
            check($sformatf("char_a[%0d]", rec_chars), {25'd0, dados_a}, {25'd0, ea});
            check($sformatf("char_z[%0d]", rec_chars), {25'd0, dados_z}, {25'd0, ez});
          end
          rec_chars++;
        end
        if (fim_a) begin
          check("record_len", rec_chars, 32'd9);
          rec_chars = 0;
        end
      end
    end
  endtask

  initial begin
    vecs[0] = '{12'h045, 16'h0123, 1'b0,
                {8'h30,8'h34,8'h35,8'h2C,8'h30,8'h31,8'h32,8'h33,8'h23},
                {8'h30,8'h34,8'h35,8'h2C,8'h20,8'h31,8'h32,8'h33,8'h23}};
    vecs[1] = '{12'h000, 16'h0007, 1'b0,
                {8'h30,8'h30,8'h30,8'h2C,8'h30,8'h30,8'h30,8'h37,8'h23},
                {8'h30,8'h30,8'h30,8'h2C,8'h20,8'h20,8'h20,8'h37,8'h23}};
    vecs[2] = '{12'h999, 16'h0000, 1'b0,
                {8'h39,8'h39,8'h39,8'h2C,8'h30,8'h30,8'h30,8'h30,8'h23},
                {8'h39,8'h39,8'h39,8'h2C,8'h20,8'h20,8'h20,8'h30,8'h23}};
    vecs[3] = '{12'h180, 16'h0123, 1'b1,
                {8'h31,8'h38,8'h30,8'h2C,8'h2D,8'h2D,8'h2D,8'h2D,8'h23},
                {8'h31,8'h38,8'h30,8'h2C,8'h2D,8'h2D,8'h2D,8'h2D,8'h23}};
    vecs[4] = '{12'h045, 16'h0A00, 1'b0,
                {8'h30,8'h34,8'h35,8'h2C,8'h30,8'h3F,8'h30,8'h30,8'h23},
                {8'h30,8'h34,8'h35,8'h2C,8'h20,8'h3F,8'h30,8'h30,8'h23}};
    vecs[5] = '{12'h0F0, 16'h5000, 1'b0,
                {8'h30,8'h3F,8'h30,8'h2C,8'h35,8'h30,8'h30,8'h30,8'h23},
                {8'h30,8'h3F,8'h30,8'h2C,8'h35,8'h30,8'h30,8'h30,8'h23}};

    reset = 1'b1; grava = 1'b0; erro = 1'b0; angulo = '0; medida = '0;
    pronto_man = 1'b0;
    fork monitor(); join_none
    repeat (3) @(negedge clock);
    check("rst_partida",  {31'd0, partida_a}, 32'd0);
    check("rst_dados",    {25'd0, dados_a}, 32'd0);
    check("rst_vazio",    {31'd0, vazio_a}, 32'd1);
    check("rst_cheio",    {31'd0, cheio_a}, 32'd0);
    check("rst_ocupado",  {31'd0, ocupado_a}, 32'd0);
    check("rst_fim",      {31'd0, fim_a}, 32'd0);
    check("rst_perdidos", {24'd0, perdidos_a}, 32'd0);
    check("rst_estado",   {28'd0, db_a}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // Basic record and start-up latency.
    drive_grava(0, 1'b1);
    check("lat_t1_vazio", {31'd0, vazio_a}, 32'd0);
    check("lat_t1_estado", {28'd0, db_a}, 32'd0);
    @(negedge clock);
    check("lat_t2_estado", {28'd0, db_a}, 32'd1);
    @(negedge clock);
    check("lat_t3_partida", {31'd0, partida_a}, 32'd1);
    check("lat_t3_ocupado", {31'd0, ocupado_a}, 32'd1);
    wait_fim("rec0");
    @(negedge clock);
    check("after_fim_pulse", {31'd0, fim_a}, 32'd0);
    check("after_fim_ocupado", {31'd0, ocupado_a}, 32'd0);
    check("after_fim_vazio", {31'd0, vazio_a}, 32'd1);
    check("after_fim_estado", {28'd0, db_a}, 32'd0);

    // Table of single records.
    for (int n = 1; n < 6; n++) begin
      drive_grava(n, 1'b1);
      wait_fim($sformatf("vec%0d", n));
      @(negedge clock);
      check($sformatf("vec%0d_fim_once", n), {31'd0, fim_a}, 32'd0);
    end

    // Burst of six while a record is in flight: four kept, two dropped.
    drive_grava(0, 1'b1);
    begin
      bit got = 1'b0;
      for (int c = 0; c < 100 && !got; c++) begin
        @(negedge clock);
        if (db_a == 4'd3) got = 1'b1;
      end
      check("reach_espera", {31'd0, got}, 32'd1);
    end
    for (int b = 0; b < 6; b++) drive_grava(1 + (b % 5), b < 4);
    check("burst_perdidos", {24'd0, perdidos_a}, 32'd2);
    check("burst_cheio", {31'd0, cheio_a}, 32'd1);
    wait_fim("burst_inflight");
    @(negedge clock);
    check("full_carrega", {28'd0, db_a}, 32'd1);
    check("full_cheio_pre", {31'd0, cheio_a}, 32'd1);
    drive_grava(2, 1'b1);
    check("popwrite_cheio", {31'd0, cheio_a}, 32'd1);
    check("popwrite_perdidos", {24'd0, perdidos_a}, 32'd2);
    check("popwrite_partida", {31'd0, partida_a}, 32'd1);
    for (int r = 0; r < 5; r++) begin
      wait_fim($sformatf("burst_rec%0d", r));
      @(negedge clock);
      if (r < 4) check($sformatf("b2b_carrega%0d", r), {28'd0, db_a}, 32'd1);
    end
    check("burst_end_vazio", {31'd0, vazio_a}, 32'd1);
    check("burst_end_estado", {28'd0, db_a}, 32'd0);
    check("queue_drained", q_a.size(), 32'd0);

    // Reset in ESPERA at character index 3.
    drive_grava(0, 1'b1);
    drive_grava(3, 1'b0);
    begin
      bit got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clock);
        if (rec_chars == 4 && db_a == 4'd3) got = 1'b1;
      end
      check("reach_idx3", {31'd0, got}, 32'd1);
    end
    check("pre_rst_vazio", {31'd0, vazio_a}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_partida", {31'd0, partida_a}, 32'd0);
    check("mid_rst_vazio", {31'd0, vazio_a}, 32'd1);
    check("mid_rst_ocupado", {31'd0, ocupado_a}, 32'd0);
    check("mid_rst_estado", {28'd0, db_a}, 32'd0);
    check("mid_rst_dados", {25'd0, dados_a}, 32'd0);
    check("mid_rst_perdidos", {24'd0, perdidos_a}, 32'd0);
    q_a.delete();
    q_z.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    pronto_man = 1'b1;
    @(negedge clock);
    pronto_man = 1'b0;
    begin
      int n_partida = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clock);
        if (partida_a || partida_z) n_partida++;
      end
      check("stray_pronto_partidas", n_partida, 32'd0);
    end
    check("stray_pronto_estado", {28'd0, db_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
